uart_receiver: RTL and testbench

Asynchronous serial receiver: 8N1, LSB first, idle-high line. It is the receive-side counterpart of `uart_transmitter` and is baud-compatible with it. It synchronizes the external `rx` pin, detects and validates start bits, and mid-bit samples 8 data bits and the stop bit. Each good byte is presented on a one-entry valid/ready output register, and framing and overrun events are reported as single-cycle pulses.

---
 rtl/uart_receiver.sv | 151 +++++++++++++++
 tb/tb_uart_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 asynchronous serial receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-entry valid/ready output register with frame-error and overrun pulses.
module uart_receiver #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] read_data,
  output logic       read_valid,
  input  logic       read_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned N  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned H  = N / 2;
  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s_q;
  logic [7:0]      read_data_q;
  logic            read_valid_q, frame_error_q, overrun_q;

  // Sync flops reset high so a reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A completing byte may replace one being consumed in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q   <= 8'h00;
      read_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      frame_error_q <= ferr_q;
      overrun_q     <= 1'b0;
      if (done_q) begin
        if (!read_valid_q || read_ready) begin
          read_data_q  <= shift_q;
          read_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (read_valid_q && read_ready) begin
        read_valid_q <= 1'b0;
      end
    end
  end

  assign read_data   = read_data_q;
  assign read_valid  = read_valid_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed table, hand-written corner
// sequences and randomized frames checked against a queue-based byte model.
module tb_uart_receiver;

  localparam int unsigned CLK_FREQ  = 1_600_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int N   = CLK_FREQ / BAUD_RATE;
  localparam int H   = N / 2;
  localparam int LAT = 9 * N + H + 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       read_ready;
  logic [7:0] read_data;
  logic       read_valid;
  logic       frame_error;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int t0_cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  int         lat_q[$];

  uart_receiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .read_data  (read_data),
    .read_valid (read_valid),
    .read_ready (read_ready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation side: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (reset_n) begin
      if (read_valid && !prev_valid) lat_q.push_back(cyc - t0_cyc);
      if (read_valid && read_ready) got_q.push_back(read_data);
      if (read_valid) valid_cycles <= valid_cycles + 1;
      if (frame_error) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
    end
    prev_valid <= read_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      errors++;
      $display("FAIL %s: latency %0d expected %0d +/-1", name, lat, LAT);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    t0_cyc = cyc + 1;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (N) tick();
    end
    rx = stop;
    repeat (N) tick();
    rx = 1'b1;
  endtask

  int fe0, ov0, vc0;
  task automatic start_scn();
    got_q.delete();
    lat_q.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    vc0 = valid_cycles;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_fe;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  logic [7:0] b;
  logic       good;
  int         fe_exp;
  string      msg;

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_fe: 1'b1};
    vecs[4] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_fe: 1'b0};
    vecs[5] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_fe: 1'b0};

    rx = 1'b1;
    read_ready = 1'b1;
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(read_valid), 32'd0);
    check("rst_data", 32'(read_data), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Directed table
    for (int v = 0; v < 6; v++) begin
      start_scn();
      send_frame(vecs[v].data, vecs[v].stop);
      repeat (2 * N) tick();
      check($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_fe", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d_vcyc", v), 32'(valid_cycles - vc0), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid && got_q.size() > 0) begin
        check($sformatf("vec%0d_data", v), 32'(got_q[0]), 32'(vecs[v].data));
        check_lat($sformatf("vec%0d_lat", v), lat_q.size() > 0 ? lat_q[0] : -1);
      end
    end

    // Back-to-back string
    start_scn();
    msg = "Hello, world!\r\n";
    for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 1'b1);
    repeat (2 * N) tick();
    check("hello_count", 32'(got_q.size()), 32'(msg.len()));
    for (int i = 0; i < msg.len() && i < got_q.size(); i++)
      check($sformatf("hello_%0d", i), 32'(got_q[i]), 32'(msg[i]));
    check("hello_fe", 32'(fe_cnt - fe0), 32'd0);

    // Glitch start
    start_scn();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (3 * N) tick();
    check("glitch_none", 32'(got_q.size()), 32'd0);
    check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
    send_frame(8'hA3, 1'b1);
    repeat (2 * N) tick();
    check("glitch_next_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("glitch_next_data", 32'(got_q[0]), 32'hA3);

    // Framing error with break
    start_scn();
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (3 * N) tick();
    rx = 1'b1;
    repeat (2 * N) tick();
    check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_none", 32'(got_q.size()), 32'd0);
    send_frame(8'h7E, 1'b1);
    repeat (2 * N) tick();
    check("ferr_next_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("ferr_next_data", 32'(got_q[0]), 32'h7E);

    // Overrun
    start_scn();
    read_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2 * N) tick();
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid", 32'(read_valid), 32'd1);
    check("ovr_data", 32'(read_data), 32'h11);
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    tick();
    check("ovr_cleared", 32'(read_valid), 32'd0);
    check("ovr_taken", 32'(got_q.size()), 32'd1);
    read_ready = 1'b1;
    repeat (N) tick();

    // Reset during data bit 4 of 0xF0
    start_scn();
    b = 8'hF0;
    rx = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (N) tick();
    end
    rx = b[4];
    repeat (H) tick();
    reset_n = 1'b0;
    repeat (2) tick();
    check("mid_rst_valid", 32'(read_valid), 32'd0);
    check("mid_rst_data", 32'(read_data), 32'd0);
    check("mid_rst_fe", 32'(frame_error), 32'd0);
    check("mid_rst_ov", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    repeat (N - H) tick();
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      repeat (N) tick();
    end
    rx = 1'b1;
    repeat (3 * N) tick();
    check("mid_rst_none", 32'(got_q.size()), 32'd0);
    send_frame(8'h0F, 1'b1);
    repeat (2 * N) tick();
    check("mid_rst_next_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("mid_rst_next_data", 32'(got_q[0]), 32'h0F);

    // Randomized frames against the byte-queue model
    start_scn();
    exp_q.delete();
    fe_exp = 0;
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      good = ($urandom_range(4) != 0);
      send_frame(b, good);
      if (good) exp_q.push_back(b);
      else fe_exp++;
      repeat (good ? $urandom_range(2 * N) : N + $urandom_range(N)) tick();
    end
    repeat (2 * N) tick();
    check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("rand_fe", 32'(fe_cnt - fe0), 32'(fe_exp));
    check("rand_ov", 32'(ov_cnt - ov0), 32'd0);
    for (int i = 0; i < lat_q.size(); i++) check_lat($sformatf("rand_lat_%0d", i), lat_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
